// File: rtl/fp16_pkg.sv
// Shared FP16 definitions: field widths, bias, special constants and the
// packed sign/exponent/fraction view used by the multiplier, adder and normalizer.
package fp16_pkg;

    localparam int unsigned FP16_WIDTH  = 16;
    localparam int unsigned FP16_EXP_W  = 5;
    localparam int unsigned FP16_FRAC_W = 10;
    localparam int unsigned FP16_BIAS   = 15;

    // Derived widths for the multiplier datapath
    localparam int unsigned FP16_MANT_W = FP16_FRAC_W + 1;
    localparam int unsigned FP16_PROD_W = 2 * FP16_MANT_W;
    localparam int unsigned FP16_ESUM_W = FP16_EXP_W + 2;

    localparam logic [FP16_WIDTH-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_WIDTH-1:0] FP16_MAX  = 16'h7BFF;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    // Zero/subnormal (exp all zeros) or Inf/NaN (exp all ones)
    function automatic logic fp16_is_special(input fp16_t x);
        return (x.exp == '0) || (x.exp == '1);
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Stage-3 combinational normalize / round / saturate / pack for the FP16
// multiplier. Truncates by default; define FP16_MULT_RNE_EN for
// round-to-nearest-even.
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic                          sign,
    input  logic                          exc_zero,
    input  logic signed [FP16_ESUM_W-1:0] esum,
    input  logic [FP16_PROD_W-1:0]        prod,
    output fp16_t                         result_c
);

    // One extra bit of headroom so normalize + rounding carries never wrap
    localparam int unsigned E_W = FP16_ESUM_W + 1;
    localparam logic signed [E_W-1:0] EXP_INF  = E_W'(2**FP16_EXP_W - 1);
    localparam logic signed [E_W-1:0] EXP_ZERO = '0;

    logic                    msb;
    logic [FP16_FRAC_W-1:0]  frac_n;
    logic [FP16_FRAC_W-1:0]  frac_r;
    logic signed [E_W-1:0]   e_n;
    logic signed [E_W-1:0]   e_r;

    assign msb = prod[FP16_PROD_W-1];

    // Normalize: product of two 1.x mantissas lies in [1,4)
    always_comb begin
        frac_n = prod[FP16_PROD_W-3 -: FP16_FRAC_W];
        e_n    = E_W'(esum);
        if (msb) begin
            frac_n = prod[FP16_PROD_W-2 -: FP16_FRAC_W];
            e_n    = E_W'(esum) + E_W'(1);
        end
    end

`ifdef FP16_MULT_RNE_EN
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [FP16_FRAC_W:0]   frac_sum;

    // Round to nearest, ties to even; a fraction carry bumps the exponent
    always_comb begin
        guard  = prod[FP16_FRAC_W-1];
        sticky = |prod[FP16_FRAC_W-2:0];
        if (msb) begin
            guard  = prod[FP16_FRAC_W];
            sticky = |prod[FP16_FRAC_W-1:0];
        end
        round_up = guard & (sticky | frac_n[0]);
        frac_sum = (FP16_FRAC_W+1)'(frac_n) + (FP16_FRAC_W+1)'(round_up);
        frac_r   = frac_sum[FP16_FRAC_W-1:0];
        e_r      = e_n;
        if (frac_sum[FP16_FRAC_W]) begin
            e_r = e_n + E_W'(1);
        end
    end
`else
    // Truncation: bits below the kept LSB are simply dropped
    logic unused_low;
    assign unused_low = ^prod[FP16_FRAC_W-1:0];
    assign frac_r     = frac_n;
    assign e_r        = e_n;
`endif

    // Exceptions flush to +0, underflow flushes, overflow saturates to max finite
    always_comb begin
        result_c = fp16_t'(FP16_ZERO);
        if (!exc_zero && (e_r > EXP_ZERO)) begin
            if (e_r >= EXP_INF) begin
                result_c = fp16_t'({sign, FP16_MAX[FP16_WIDTH-2:0]});
            end else begin
                result_c.sign = sign;
                result_c.exp  = e_r[FP16_EXP_W-1:0];
                result_c.frac = frac_r;
            end
        end
    end

endmodule

// File: rtl/fp16_mult_pipe.sv
// Three-stage pipelined FP16 multiplier with valid/ready on both sides.
// Stage 1 unpacks, stage 2 multiplies mantissas, stage 3 normalizes/packs
// into the registered mult_prod. Optional macro: FP16_MULT_RNE_EN (RNE rounding).
module fp16_mult_pipe
    import fp16_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FP16_WIDTH,
    parameter int unsigned EXPONENT   = FP16_EXP_W,
    parameter int unsigned MANTISSA   = FP16_FRAC_W,
    parameter int unsigned BIAS       = FP16_BIAS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] mult_prod
);

    localparam int unsigned MANT_W = MANTISSA + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned ESUM_W = EXPONENT + 2;

    logic en1, en2, en3;
    logic v1, v2, v3;

    fp16_t a_f, b_f;

    logic                     s1_sign;
    logic                     s1_exc;
    logic [MANT_W-1:0]        s1_ma;
    logic [MANT_W-1:0]        s1_mb;
    logic signed [ESUM_W-1:0] s1_esum;

    logic                     s2_sign;
    logic                     s2_exc;
    logic [PROD_W-1:0]        s2_prod;
    logic signed [ESUM_W-1:0] s2_esum;

    fp16_t rp_result;

    assign a_f = fp16_t'(op_a);
    assign b_f = fp16_t'(op_b);

    // Stall chain: a stage advances when it is empty or the one after it advances
    assign en3      = ~v3 | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;
    assign out_valid = v3;

    // Valid bits and the output register; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            mult_prod <= FP16_ZERO;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) begin
                v3 <= v2;
                if (v2) mult_prod <= DATA_WIDTH'(rp_result);
            end
        end
    end

    // Stage 1/2 datapath: only loaded with valid data, no reset needed
    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            s1_sign <= a_f.sign ^ b_f.sign;
            s1_exc  <= fp16_is_special(a_f) | fp16_is_special(b_f);
            s1_ma   <= {1'b1, a_f.frac};
            s1_mb   <= {1'b1, b_f.frac};
            s1_esum <= ESUM_W'(a_f.exp) + ESUM_W'(b_f.exp) - ESUM_W'(BIAS);
        end
        if (en2 && v1) begin
            s2_sign <= s1_sign;
            s2_exc  <= s1_exc;
            s2_esum <= s1_esum;
            s2_prod <= PROD_W'(s1_ma) * PROD_W'(s1_mb);
        end
    end

    fp16_round_pack u_round_pack (
        .sign     (s2_sign),
        .exc_zero (s2_exc),
        .esum     (s2_esum),
        .prod     (s2_prod),
        .result_c (rp_result)
    );

endmodule

// File: tb/tb_fp16_mult_pipe.sv
// Self-checking bench for fp16_mult_pipe: directed values, exceptions,
// rounding, back-pressure, throughput, random traffic and mid-stream reset.
module tb_fp16_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] mult_prod;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_no = 0;
    int n_deliv  = 0;
    logic lat_chk = 1'b0;
    logic last_in_ready;

    logic [15:0] exp_q[$];
    int          cyc_q[$];

    localparam logic [15:0] RND_EXP =
`ifdef FP16_MULT_RNE_EN
        16'h3E03;
`else
        16'h3E02;
`endif

    localparam logic [15:0] DIR_A [10] = '{16'h3C00, 16'h4000, 16'h3E00, 16'hC000, 16'h7C00,
                                          16'h0001, 16'h0400, 16'h7800, 16'hF800, 16'h3E01};
    localparam logic [15:0] DIR_B [10] = '{16'h3C00, 16'h4200, 16'h3E00, 16'h4000, 16'h3C00,
                                          16'h3C00, 16'h0400, 16'h7800, 16'h7800, 16'h3C01};
    localparam logic [15:0] DIR_E [10] = '{16'h3C00, 16'h4600, 16'h4080, 16'hC400, 16'h0000,
                                          16'h0000, 16'h0000, 16'h7BFF, 16'hFBFF, RND_EXP};

    fp16_mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mult_prod (mult_prod)
    );

    always #5 clk = ~clk;

    // Reference: real-valued view of the format using integer arithmetic
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea = int'(a[14:10]);
        int eb = int'(b[14:10]);
        int s  = int'(a[15] ^ b[15]);
        int p, e, sh, frac;
`ifdef FP16_MULT_RNE_EN
        int rem, half;
`endif
        if (ea == 0 || eb == 0 || ea == 31 || eb == 31) return 16'h0000;
        p = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        e = ea + eb - 15;
        if (p >= 2097152) begin sh = 11; e = e + 1; end
        else sh = 10;
        frac = (p >> sh) - 1024;
`ifdef FP16_MULT_RNE_EN
        rem  = p - ((p >> sh) << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (frac % 2) == 1)) frac = frac + 1;
        if (frac == 1024) begin frac = 0; e = e + 1; end
`endif
        if (e <= 0) return 16'h0000;
        if (e >= 31) return {s[0], 15'h7BFF};
        return {s[0], e[4:0], frac[9:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v = 16'($urandom);
        if ($urandom_range(7) != 0) v[14:10] = 5'($urandom_range(22, 8));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge+1, sample handshakes at negedge, score deliveries
    task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic ordy, input logic [15:0] expv, output logic acc);
        logic [15:0] e;
        int c;
        in_valid  = iv;
        op_a      = a;
        op_b      = b;
        out_ready = ordy;
        @(negedge clk);
        acc = iv & in_ready;
        last_in_ready = in_ready;
        if (out_valid && out_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check($sformatf("prod@%0d", cycle_no), 32'(mult_prod), 32'(e));
                if (lat_chk) check("latency", 32'(cycle_no - c), 32'd3);
            end
        end
        if (acc) begin
            exp_q.push_back(expv);
            cyc_q.push_back(cycle_no);
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0, acc);
        check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        logic [15:0] ca, cb, held;
        int sent, stall_left, base;
        logic first_seen;

        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mult_prod", 32'(mult_prod), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_mult_prod", 32'(mult_prod), 32'd0);
        @(posedge clk); #1;

        // Directed basic, exception and rounding vectors, back to back
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, DIR_A[i], DIR_B[i], 1'b1, DIR_E[i], acc);
            check("dir_accept", 32'(acc), 32'd1);
        end
        drain("directed");

        // Back-pressure: 8 products, out_ready low for 5 cycles from first result
        lat_chk = 1'b0;
        sent = 0; first_seen = 1'b0; stall_left = 0; held = '0;
        ca = rand_op(); cb = rand_op();
        for (int i = 0; i < 80 && (sent < 8 || exp_q.size() != 0); i++) begin
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 5;
                held = mult_prod;
            end
            if (stall_left > 0 && stall_left < 5) begin
                check("bp_hold", 32'(mult_prod), 32'(held));
                check("bp_valid", 32'(out_valid), 32'd1);
            end
            cycle(sent < 8, ca, cb, stall_left == 0, model(ca, cb), acc);
            if (stall_left > 0) begin
                check("bp_in_ready_low", 32'(last_in_ready), 32'd0);
                stall_left--;
            end
            if (acc) begin
                sent++;
                ca = rand_op(); cb = rand_op();
            end
        end
        check("bp_sent", 32'(sent), 32'd8);
        check("bp_left", 32'(exp_q.size()), 32'd0);

        // Throughput: 20 consecutive accepts, each result exactly 3 cycles later
        lat_chk = 1'b1;
        base = n_deliv;
        for (int i = 0; i < 20; i++) begin
            ca = rand_op(); cb = rand_op();
            cycle(1'b1, ca, cb, 1'b1, model(ca, cb), acc);
            check("tput_accept", 32'(acc), 32'd1);
        end
        drain("tput");
        check("tput_count", 32'(n_deliv - base), 32'd20);

        // Random traffic with random stalls on both sides
        lat_chk = 1'b0;
        sent = 0;
        ca = rand_op(); cb = rand_op();
        for (int i = 0; i < 2000 && sent < 150; i++) begin
            cycle($urandom_range(3) != 0, ca, cb, $urandom_range(9) < 7, model(ca, cb), acc);
            if (acc) begin
                sent++;
                ca = rand_op(); cb = rand_op();
            end
        end
        check("rand_sent", 32'(sent), 32'd150);
        drain("rand");

        // Reset with two products in flight
        ca = rand_op(); cb = rand_op();
        cycle(1'b1, ca, cb, 1'b1, model(ca, cb), acc);
        ca = rand_op(); cb = rand_op();
        cycle(1'b1, ca, cb, 1'b1, model(ca, cb), acc);
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, acc);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_prod", 32'(mult_prod), 32'd0);
        exp_q.delete();
        cyc_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'h0, acc);
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end
        lat_chk = 1'b1;
        ca = 16'h4000; cb = 16'h4200;
        cycle(1'b1, ca, cb, 1'b1, 16'h4600, acc);
        check("rst_after_accept", 32'(acc), 32'd1);
        drain("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
